// File: rtl/matmul_pkg.sv
// Shared loader state encoding and default matrix dimensions for the matmul datapath.
package matmul_pkg;

    localparam int M_DEF  = 8;
    localparam int N_DEF  = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        FLUSH  = 3'd3,
        KICK   = 3'd4
    } load_state_e;

    function automatic logic is_loading(input load_state_e s);
        return (s == LOAD_A) || (s == LOAD_B);
    endfunction

endpackage

// File: rtl/matload_addr_cnt.sv
// Terminal-count address counter: counts 0..TC-1, returns to 0 after the terminal count.
module matload_addr_cnt #(
    parameter int            AW = 16,
    parameter logic [AW-1:0] TC = AW'(64)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [AW-1:0] cnt_o,
    output logic          done_o
);

    localparam logic [AW-1:0] LAST = TC - AW'(1);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // Next count; terminal count folds back to zero so the next matrix starts clean
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {AW{1'b0}};
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = {AW{1'b0}};
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {AW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: streams row-major A then B into two memories, then pulses start.
// Optional in_last framing check is built when MATLOAD_LAST_CHECK_EN is defined.
module matrix_loader
    import matmul_pkg::*;
#(
    parameter int m  = M_DEF,
    parameter int n  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_go,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic            m1EN,
    output logic            m1wEN,
    output logic            m2EN,
    output logic            m2wEN,
    output logic [m+n-1:0]  addr1,
    output logic [m+n-1:0]  addr2,
    output logic [DW-1:0]   wdata,
    output logic            start,
    output logic            busy,
    output logic            err
);

    localparam int            AW = m + n;
    localparam logic [AW-1:0] TC = AW'(m * n);

    load_state_e   state_q;
    load_state_e   state_d;
    logic          in_ready_q;
    logic          busy_q;
    logic          start_q;
    logic          m1_we_q;
    logic          m2_we_q;
    logic [AW-1:0] addr1_q;
    logic [AW-1:0] addr2_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic          xfer_s;
    logic          cnt_en_s;
    logic          cnt_clr_s;
    logic          cnt_last_s;
    logic [AW-1:0] cnt_s;

    assign xfer_s = in_valid && in_ready_q;

    matload_addr_cnt #(
        .AW (AW),
        .TC (TC)
    ) u_addr_cnt (
        .clk_i   (clk),
        .rst_n_i (rst),
        .clr_i   (cnt_clr_s),
        .en_i    (cnt_en_s),
        .cnt_o   (cnt_s),
        .done_o  (cnt_last_s)
    );

    // Next-state and counter control
    always_comb begin
        state_d   = state_q;
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_go) begin
                    state_d   = LOAD_A;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_A: begin
                cnt_en_s = xfer_s;
                if (xfer_s && cnt_last_s) begin
                    state_d = LOAD_B;
                end else begin
                    state_d = LOAD_A;
                end
            end
            LOAD_B: begin
                cnt_en_s = xfer_s;
                if (xfer_s && cnt_last_s) begin
                    state_d = FLUSH;
                end else begin
                    state_d = LOAD_B;
                end
            end
            FLUSH:   state_d = KICK;
            KICK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; handshake and status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= is_loading(state_d);
            busy_q     <= (state_d != IDLE);
            start_q    <= (state_d == KICK);
        end
    end

    // Write port: element and address captured on transfer, presented one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1_we_q <= 1'b0;
            m2_we_q <= 1'b0;
            addr1_q <= {AW{1'b0}};
            addr2_q <= {AW{1'b0}};
            wdata_q <= {DW{1'b0}};
        end else begin
            m1_we_q <= xfer_s && (state_q == LOAD_A);
            m2_we_q <= xfer_s && (state_q == LOAD_B);
            if (xfer_s) begin
                wdata_q <= in_data;
            end
            if (xfer_s && (state_q == LOAD_A)) begin
                addr1_q <= cnt_s;
            end
            if (xfer_s && (state_q == LOAD_B)) begin
                addr2_q <= cnt_s;
            end
        end
    end

`ifdef MATLOAD_LAST_CHECK_EN
    logic final_beat_s;
    assign final_beat_s = (state_q == LOAD_B) && cnt_last_s;

    // Sticky framing error: in_last must be high on the final B beat and nowhere else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && load_go) begin
            err_q <= 1'b0;
        end else if (xfer_s && (in_last != final_beat_s)) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end
`else
    logic last_unused_s;
    assign last_unused_s = in_last;
    assign err_q         = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign m1EN     = m1_we_q;
    assign m1wEN    = m1_we_q;
    assign m2EN     = m2_we_q;
    assign m2wEN    = m2_we_q;
    assign addr1    = addr1_q;
    assign addr2    = addr2_q;
    assign wdata    = wdata_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
